// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd2bin_seq_mac.sv
// One multiply-by-10-and-add step: sum = (acc*10 + d) mod 2^W, with
// flags for lost upper bits and for a non-decimal digit.
module bcd_digit_mac
    import bcd2bin_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]       acc,
    input  logic [DIGIT_W-1:0] d,
    output logic [W-1:0]       sum,
    output logic               carry_nz,
    output logic               bad_digit
);

    logic [W+3:0] acc_ext_s;
    logic [W+3:0] t_s;

    // acc*10 as (acc<<3)+(acc<<1); the extra 4 bits hold the full product plus digit
    always_comb begin
        acc_ext_s = {4'b0000, acc};
        t_s       = (acc_ext_s << 3) + (acc_ext_s << 1) + {{W{1'b0}}, d};
        sum       = t_s[W-1:0];
        carry_nz  = (t_s[W+3:W] != 4'b0000);
        bad_digit = (d > 4'd9);
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// with a start/done handshake and registered result/flag outputs.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int DIGITS = 10,
    parameter int W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          bin_out,
    output logic                  err_digit,
    output logic                  overflow
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t                 state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [4*DIGITS-1:0]    shift_r;
    logic [W-1:0]           acc_r;
    logic                   err_r;
    logic                   ovf_r;
    logic                   busy_r;
    logic                   done_r;
    logic [W-1:0]           bin_out_r;
    logic                   err_digit_r;
    logic                   overflow_r;

    logic [DIGIT_W-1:0]     digit_s;
    logic [W-1:0]           sum_s;
    logic                   carry_nz_s;
    logic                   bad_digit_s;
    logic                   load_s;

    assign digit_s = shift_r[4*DIGITS-1 -: DIGIT_W];

    bcd_digit_mac #(.W(W)) u_mac (
        .acc       (acc_r),
        .d         (digit_s),
        .sum       (sum_s),
        .carry_nz  (carry_nz_s),
        .bad_digit (bad_digit_s)
    );

    // Next-state logic; start is only honoured when the block is ready
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CONV;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CONV: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CONV;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = CONV;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
                load_s       = 1'b0;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CONV);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Datapath: operand load, per-digit accumulate and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {(4*DIGITS){1'b0}};
            acc_r   <= {W{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (load_s) begin
            cnt_r   <= CNT_LAST;
            shift_r <= bcd_in;
            acc_r   <= {W{1'b0}};
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == CONV) begin
            acc_r   <= sum_s;
            err_r   <= err_r | bad_digit_s;
            ovf_r   <= ovf_r | carry_nz_s;
            shift_r <= shift_r << DIGIT_W;
            if (cnt_r != {CNT_W{1'b0}}) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
            acc_r   <= acc_r;
            err_r   <= err_r;
            ovf_r   <= ovf_r;
        end
    end

    // Result registers take the final step directly so they are valid with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out_r   <= {W{1'b0}};
            err_digit_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if ((state_r == CONV) && (cnt_r == {CNT_W{1'b0}})) begin
            bin_out_r   <= sum_s;
            err_digit_r <= err_r | bad_digit_s;
            overflow_r  <= ovf_r | carry_nz_s;
        end else begin
            bin_out_r   <= bin_out_r;
            err_digit_r <= err_digit_r;
            overflow_r  <= overflow_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign bin_out   = bin_out_r;
    assign err_digit = err_digit_r;
    assign overflow  = overflow_r;

endmodule
